// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer and lock supervisor producing the system reset
//
// Purpose: holds the PLL in reset, waits for a lock that stays stable, then releases a
//          synchronous system reset. Lock loss re-asserts system reset and restarts the PLL.
//          A lock timeout retries the PLL reset sequence.
// Ports:
//   clk            in   reference clock, the only clock
//   reset          in   synchronous, active-high
//   pll_lock       in   PLL LOCK, asynchronous to clk
//   pll_reset      out  to PLL RESET, active-high
//   rst_out        out  system reset, synchronous to clk, active-high
//   locked         out  high only while running with a stable lock
//   retry_cnt      out  lock timeouts, saturates at 15
//   lock_loss_cnt  out  lock losses while running, saturates at 255
// Configuration: define LOCK_LOSS_CNT_EN to build the lock_loss_cnt counter;
//                otherwise lock_loss_cnt is tied to zero.

module pll_lock_supervisor #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_STABLE  = 1024,
    parameter int CNT_W        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       rst_out,
    output logic       locked,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        S_PRST   = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             sync1;
    logic             sync2;
    logic             lock_s;

    // pll_lock is asynchronous; only the second synchroniser stage is used by the FSM.
    assign lock_s = sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_PRST;
            timer     <= '0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            pll_reset <= 1'b1;
            rst_out   <= 1'b1;
            locked    <= 1'b0;
            retry_cnt <= 4'd0;
`ifdef LOCK_LOSS_CNT_EN
            lock_loss_cnt <= 8'd0;
`endif
        end else begin
            sync1 <= pll_lock;
            sync2 <= sync1;
            // Outputs are updated together with the state so they always match the state entered.
            case (state)
                S_PRST: begin
                    if (timer == RST_LAST) begin
                        state     <= S_WAIT;
                        timer     <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state     <= S_PRST;
                        timer     <= '0;
                        pll_reset <= 1'b1;
                        if (retry_cnt != 4'd15) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                S_STABLE: begin
                    // A drop back to WAIT is not a timeout, so retry_cnt is left alone.
                    if (!lock_s) begin
                        state <= S_WAIT;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state   <= S_RUN;
                        timer   <= '0;
                        rst_out <= 1'b0;
                        locked  <= 1'b1;
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_PRST;
                        timer     <= '0;
                        pll_reset <= 1'b1;
                        rst_out   <= 1'b1;
                        locked    <= 1'b0;
`ifdef LOCK_LOSS_CNT_EN
                        if (lock_loss_cnt != 8'd255) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state     <= S_PRST;
                    timer     <= '0;
                    pll_reset <= 1'b1;
                    rst_out   <= 1'b1;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

`ifndef LOCK_LOSS_CNT_EN
    assign lock_loss_cnt = 8'd0;
`endif

endmodule
